// File: rtl/seq_mult_ctrl_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } mult_state_t;

   // Magnitude of the n-bit two's-complement value held in the low n bits of v.
   // Only the low n bits of the result are meaningful; -2^(n-1) maps to 2^(n-1).
   function automatic logic [31:0] abs_n(input logic [31:0] v, input int unsigned n);
      logic [31:0] sh;
      sh = v >> (n - 1);
      return sh[0] ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/seq_mult_ctrl_if.sv
// Request/result bundle between a multiply requester and seq_mult_ctrl.
interface seq_mult_ctrl_if #(
   parameter int N = 8
);
   logic           start;
   logic           signed_mode;
   logic [N-1:0]   multiplicand;
   logic [N-1:0]   multiplier;
   logic [2*N-1:0] product;
   logic           busy;
   logic           done;

   modport master (
      output start, signed_mode, multiplicand, multiplier,
      input  product, busy, done
   );

   modport slave (
      input  start, signed_mode, multiplicand, multiplier,
      output product, busy, done
   );
endinterface

// File: rtl/seq_mult_ctrl_shift_add_reg.sv
// A/Q/M datapath register with fused add-and-shift, one partial product per step.
module shift_add_reg #(
   parameter int N = 8
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           load,
   input  logic           step,
   input  logic [N-1:0]   m_in,
   input  logic [N-1:0]   q_in,
   output logic [2*N-1:0] aq
);

   logic [N-1:0] a_q, a_d;
   logic [N-1:0] q_q, q_d;
   logic [N-1:0] m_q, m_d;
   logic [N:0]   sum;

   // Load operands or perform one add-shift step; the carry C is sum[N],
   // consumed by the same-cycle shift, so it never needs its own flop.
   always_comb begin
      a_d = a_q;
      q_d = q_q;
      m_d = m_q;
      sum = {1'b0, a_q} + (q_q[0] ? {1'b0, m_q} : '0);
      if (load) begin
         a_d = '0;
         q_d = q_in;
         m_d = m_in;
      end else if (step) begin
         a_d = sum[N:1];
         q_d = {sum[0], q_q[N-1:1]};
      end
   end

   // Datapath state registers, synchronously cleared.
   always_ff @(posedge clock) begin
      if (reset) begin
         a_q <= '0;
         q_q <= '0;
         m_q <= '0;
      end else begin
         a_q <= a_d;
         q_q <= q_d;
         m_q <= m_d;
      end
   end

   assign aq = {a_q, q_q};

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential N-bit multiplier: controller FSM, iteration counter, sign
// correction and result registers around the shift_add_reg datapath.
module seq_mult_ctrl
   import mult_pkg::*;
#(
   parameter int N = 8
) (
   input  logic          clock,
   input  logic          reset,
   seq_mult_ctrl_if.slave bus
);

   localparam int CW = $clog2(N + 1);

   mult_state_t    state_q, state_d;
   logic [CW-1:0]  count_q, count_d;
   logic           neg_q, neg_d;
   logic [2*N-1:0] product_q, product_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;

   logic           load, step;
   logic [N-1:0]   m_in, q_in;
   logic [2*N-1:0] aq;

   // Operand magnitudes presented to the datapath (raw values in unsigned mode).
   always_comb begin
      m_in = bus.multiplicand;
      q_in = bus.multiplier;
      if (bus.signed_mode) begin
         m_in = N'(abs_n(32'(bus.multiplicand), N));
         q_in = N'(abs_n(32'(bus.multiplier), N));
      end
   end

   // Next-state, counter, sign and result logic.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      neg_d     = neg_q;
      product_d = product_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      load      = 1'b0;
      step      = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               load    = 1'b1;
               count_d = CW'(N);
               neg_d   = bus.signed_mode &
                         (bus.multiplicand[N-1] ^ bus.multiplier[N-1]);
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            step    = 1'b1;
            count_d = count_q - 1'b1;
            if (count_q == CW'(1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            product_d = neg_q ? -aq : aq;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Controller and result registers, synchronously cleared.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         count_q   <= '0;
         neg_q     <= 1'b0;
         product_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         neg_q     <= neg_d;
         product_q <= product_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   shift_add_reg #(.N(N)) u_datapath (
      .clock (clock),
      .reset (reset),
      .load  (load),
      .step  (step),
      .m_in  (m_in),
      .q_in  (q_in),
      .aq    (aq)
   );

   assign bus.product = product_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;

endmodule
